// File: rtl/q_packet_tx_pkg.sv
// q_packet_tx_pkg
// Shared definitions for the Q-routing packet transmitter:
//   - table/stream word width and neighbour-table index width
//   - packet-type codes carried in word 0
//   - word-position constants for the outgoing packet
//   - FSM state encoding
//   - NO_ROUTE_ID, the next-hop ID reported when the table is empty
package q_packet_tx_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int IDX_WIDTH  = 5;

  // Packet-type codes (upper three bits of word 0).
  localparam logic [2:0] PKT_BEACON = 3'b001;
  localparam logic [2:0] PKT_HELLO  = 3'b010;
  localparam logic [2:0] PKT_ACK    = 3'b011;
  localparam logic [2:0] PKT_DATA   = 3'b101;

  // Word positions inside the outgoing packet.
  localparam logic [2:0] W_TYPE     = 3'd0;
  localparam logic [2:0] W_NODE_ID  = 3'd1;
  localparam logic [2:0] W_HOPS     = 3'd2;
  localparam logic [2:0] W_CLUSTER  = 3'd3;
  localparam logic [2:0] W_ENERGY   = 3'd4;
  localparam logic [2:0] W_BEST_Q   = 3'd5;
  localparam logic [2:0] W_BEST_ID  = 3'd6;
  localparam logic [2:0] W_CHECKSUM = 3'd7;

  localparam logic [WORD_WIDTH-1:0] NO_ROUTE_ID = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/q_packet_tx_max_scan.sv
// q_max_scan
// Pipelined argmax over the neighbour table. A start pulse loads the entry
// count and clears the running best (bestQ=0, bestID=NO_ROUTE_ID). One read
// address is issued per cycle; the table answers one cycle later, so the
// compare for index i happens in the cycle after index i was issued.
// scan_done is high in the cycle of the final compare; best_q/best_id hold
// the final result from the following cycle on.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            load count and clear the running best
//   count            number of entries to scan (already saturated)
//   rd_index         table read address
//   src_id, q_value  table read data (one cycle after rd_index)
//   best_q, best_id  running / final maximum
//   scan_done        final compare in progress this cycle
module q_max_scan
  import q_packet_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_WIDTH:0]    count,
  output logic [IDX_WIDTH-1:0]  rd_index,
  input  logic [WORD_WIDTH-1:0] src_id,
  input  logic [WORD_WIDTH-1:0] q_value,
  output logic [WORD_WIDTH-1:0] best_q,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic                  scan_done
);

  logic                  active_q, active_d;
  logic [IDX_WIDTH:0]    iss_cnt_q, iss_cnt_d;
  logic [IDX_WIDTH:0]    count_q, count_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic                  first_q, first_d;
  logic [WORD_WIDTH-1:0] best_q_q, best_q_d;
  logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
  logic                  issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      iss_cnt_q <= '0;
      count_q   <= '0;
      cmp_vld_q <= 1'b0;
      first_q   <= 1'b0;
      best_q_q  <= '0;
      best_id_q <= NO_ROUTE_ID;
    end else begin
      active_q  <= active_d;
      iss_cnt_q <= iss_cnt_d;
      count_q   <= count_d;
      cmp_vld_q <= cmp_vld_d;
      first_q   <= first_d;
      best_q_q  <= best_q_d;
      best_id_q <= best_id_d;
    end
  end

  assign issue     = active_q && (iss_cnt_q < count_q);
  // The last compare is the one whose address was issued when the issue
  // counter reached count.
  assign scan_done = active_q && cmp_vld_q && (iss_cnt_q == count_q);
  assign rd_index  = iss_cnt_q[IDX_WIDTH-1:0];
  assign best_q    = best_q_q;
  assign best_id   = best_id_q;

  always_comb begin
    active_d  = active_q;
    iss_cnt_d = iss_cnt_q;
    count_d   = count_q;
    cmp_vld_d = cmp_vld_q;
    first_d   = first_q;
    best_q_d  = best_q_q;
    best_id_d = best_id_q;
    if (start) begin
      active_d  = (count != '0);
      iss_cnt_d = '0;
      count_d   = count;
      cmp_vld_d = 1'b0;
      first_d   = 1'b1;
      best_q_d  = '0;
      best_id_d = NO_ROUTE_ID;
    end else begin
      cmp_vld_d = issue;
      if (issue) iss_cnt_d = iss_cnt_q + 1'b1;
      if (cmp_vld_q) begin
        // Strict compare: on a tie the earlier (lower) index is kept.
        if (first_q || (q_value > best_q_q)) begin
          best_q_d  = q_value;
          best_id_d = src_id;
        end
        first_d = 1'b0;
      end
      if (scan_done) active_d = 1'b0;
    end
  end

endmodule

// File: rtl/q_packet_tx.sv
// q_packet_tx
// On an accepted start pulse, latches the node's own fields, scans the
// neighbour table for the highest Q-value (q_max_scan) and streams the packet
//   W0={packetType,0}, W1 myNodeID, W2 myHops, W3 myClusterID, W4 myEnergy,
//   W5 bestQ, W6 bestID [, W7 XOR of W0..W6 when TX_CHECKSUM_EN is defined]
// over a valid/ready stream.
// Handshake: a word transfers on a rising edge where tx_valid & tx_ready;
// once tx_valid is high it stays high with tx_data stable until that edge.
// Build macro: TX_CHECKSUM_EN adds the checksum word (8-word packet).
// Ports:
//   clk, nrst                      clock, synchronous active-high reset
//   en                             start pulse (IDLE only)
//   myNodeID/myHops/myClusterID/myEnergy, packetType, neighborCount
//                                  packet inputs, latched on accepted en
//   rd_index, mSourceID, mQValue   neighbour-table read port
//   tx_data, tx_valid, tx_ready    output stream
//   busy, noRoute, done            status
//   state_dbg                      current FSM state (state_e encoding)
module q_packet_tx
  import q_packet_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myHops,
  input  logic [WORD_WIDTH-1:0] myClusterID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [2:0]            packetType,
  input  logic [WORD_WIDTH-1:0] neighborCount,
  output logic [IDX_WIDTH-1:0]  rd_index,
  input  logic [WORD_WIDTH-1:0] mSourceID,
  input  logic [WORD_WIDTH-1:0] mQValue,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  noRoute,
  output logic                  done,
  output logic [1:0]            state_dbg
);

`ifdef TX_CHECKSUM_EN
  localparam logic [2:0] LAST_WORD = W_CHECKSUM;
`else
  localparam logic [2:0] LAST_WORD = W_BEST_ID;
`endif

  localparam logic [WORD_WIDTH-1:0] MAX_COUNT = WORD_WIDTH'(1 << IDX_WIDTH);

  state_e                state_q, state_d;
  logic [2:0]            ptype_q, ptype_d;
  logic [WORD_WIDTH-1:0] node_id_q, node_id_d;
  logic [WORD_WIDTH-1:0] hops_q, hops_d;
  logic [WORD_WIDTH-1:0] cluster_q, cluster_d;
  logic [WORD_WIDTH-1:0] energy_q, energy_d;
  logic                  no_route_q, no_route_d;
  logic [2:0]            word_cnt_q, word_cnt_d;

  logic                  accept;
  logic                  hs;
  logic [IDX_WIDTH:0]    cnt_sat;
  logic [WORD_WIDTH-1:0] best_q, best_id;
  logic                  scan_done;
  logic [WORD_WIDTH-1:0] word_mux;

  assign accept  = (state_q == ST_IDLE) && en;
  assign hs      = (state_q == ST_SEND) && tx_ready;
  assign cnt_sat = (neighborCount > MAX_COUNT) ? MAX_COUNT[IDX_WIDTH:0]
                                               : neighborCount[IDX_WIDTH:0];

  q_max_scan u_scan (
    .clk       (clk),
    .rst       (nrst),
    .start     (accept),
    .count     (cnt_sat),
    .rd_index  (rd_index),
    .src_id    (mSourceID),
    .q_value   (mQValue),
    .best_q    (best_q),
    .best_id   (best_id),
    .scan_done (scan_done)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= ST_IDLE;
      ptype_q    <= '0;
      node_id_q  <= '0;
      hops_q     <= '0;
      cluster_q  <= '0;
      energy_q   <= '0;
      no_route_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptype_q    <= ptype_d;
      node_id_q  <= node_id_d;
      hops_q     <= hops_d;
      cluster_q  <= cluster_d;
      energy_q   <= energy_d;
      no_route_q <= no_route_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = (cnt_sat == '0) ? ST_SEND : ST_SCAN;
      ST_SCAN: if (scan_done) state_d = ST_SEND;
      ST_SEND: if (hs && (word_cnt_q == LAST_WORD)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched packet fields, no-route flag and word counter.
  always_comb begin
    ptype_d    = ptype_q;
    node_id_d  = node_id_q;
    hops_d     = hops_q;
    cluster_d  = cluster_q;
    energy_d   = energy_q;
    no_route_d = no_route_q;
    word_cnt_d = word_cnt_q;
    if (accept) begin
      ptype_d    = packetType;
      node_id_d  = myNodeID;
      hops_d     = myHops;
      cluster_d  = myClusterID;
      energy_d   = myEnergy;
      no_route_d = (cnt_sat == '0);
      word_cnt_d = '0;
    end else if (hs && (word_cnt_q != LAST_WORD)) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
  end

  // Word selection for the current packet position.
  always_comb begin
    word_mux = '0;
    case (word_cnt_q)
      W_TYPE:    word_mux = {ptype_q, {(WORD_WIDTH-3){1'b0}}};
      W_NODE_ID: word_mux = node_id_q;
      W_HOPS:    word_mux = hops_q;
      W_CLUSTER: word_mux = cluster_q;
      W_ENERGY:  word_mux = energy_q;
      W_BEST_Q:  word_mux = best_q;
      W_BEST_ID: word_mux = best_id;
`ifdef TX_CHECKSUM_EN
      W_CHECKSUM: word_mux = {ptype_q, {(WORD_WIDTH-3){1'b0}}} ^ node_id_q ^
                             hops_q ^ cluster_q ^ energy_q ^ best_q ^ best_id;
`endif
      default:   word_mux = '0;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    tx_valid  = (state_q == ST_SEND);
    done      = (state_q == ST_DONE);
    tx_data   = (state_q == ST_SEND) ? word_mux : '0;
    noRoute   = no_route_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_q_packet_tx.sv
module tb_q_packet_tx;

`ifdef TX_CHECKSUM_EN
  localparam int NW = 8;
`else
  localparam int NW = 7;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [15:0] myNodeID, myHops, myClusterID, myEnergy;
  logic [2:0]  packetType;
  logic [15:0] neighborCount;
  logic [4:0]  rd_index;
  logic [15:0] mSourceID, mQValue;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic        busy, noRoute, done;
  logic [1:0]  state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  q_packet_tx dut (
    .clk(clk), .nrst(nrst), .en(en),
    .myNodeID(myNodeID), .myHops(myHops), .myClusterID(myClusterID),
    .myEnergy(myEnergy), .packetType(packetType), .neighborCount(neighborCount),
    .rd_index(rd_index), .mSourceID(mSourceID), .mQValue(mQValue),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .noRoute(noRoute), .done(done), .state_dbg(state_dbg)
  );

  // Neighbour table: synchronous read, data one cycle after rd_index.
  logic [15:0] tbl_id [32];
  logic [15:0] tbl_q  [32];
  always @(posedge clk) begin
    mSourceID <= tbl_id[rd_index];
    mQValue   <= tbl_q[rd_index];
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt, done_cnt;
  int first_valid_cyc, last_hs_cyc, done_cyc;
  bit hold_pend = 0;
  logic [15:0] hold_data;

  always @(negedge clk) begin
    if (nrst) begin
      hold_pend = 0;
    end else begin
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hold_pend) begin
        checks++;
        if (!tx_valid || tx_data !== hold_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h",
                   tx_valid, tx_data, hold_data);
        end
      end
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h with no word expected", tx_data);
        end else begin
          logic [15:0] w;
          w = exp_q.pop_front();
          if (tx_data !== w) begin
            errors++;
            $display("FAIL word%0d: got %h required %h", hs_cnt, tx_data, w);
          end
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives the packet inputs, pushes the expected packet from a reference
  // argmax over the table, pulses en and returns the accept-edge cycle.
  task automatic start_packet(input logic [2:0] pt, input logic [15:0] nid,
                              input logic [15:0] hops, input logic [15:0] cid,
                              input logic [15:0] nrg, input logic [15:0] ncnt,
                              output int k);
    int cnt;
    logic [15:0] bq, bid, w0, cs;
    cnt = (ncnt > 16'd32) ? 32 : int'(ncnt);
    bq = 16'h0000;
    bid = 16'hFFFF;
    for (int i = 0; i < cnt; i++) begin
      if (i == 0 || tbl_q[i] > bq) begin
        bq = tbl_q[i];
        bid = tbl_id[i];
      end
    end
    w0 = {pt, 13'b0};
    exp_q.push_back(w0);
    exp_q.push_back(nid);
    exp_q.push_back(hops);
    exp_q.push_back(cid);
    exp_q.push_back(nrg);
    exp_q.push_back(bq);
    exp_q.push_back(bid);
    cs = w0 ^ nid ^ hops ^ cid ^ nrg ^ bq ^ bid;
    if (NW == 8) exp_q.push_back(cs);
    hs_cnt = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    packetType = pt;
    myNodeID = nid;
    myHops = hops;
    myClusterID = cid;
    myEnergy = nrg;
    neighborCount = ncnt;
    en = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    nrst = 1'b1;
    en = 1'b0;
    tx_ready = 1'b0;
    myNodeID = '0; myHops = '0; myClusterID = '0; myEnergy = '0;
    packetType = '0; neighborCount = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rd_index !== 5'd0) begin errors++; $display("FAIL reset_rd_index: got %h required 0", rd_index); end
    checks++; if (tx_data !== 16'd0) begin errors++; $display("FAIL reset_tx_data: got %h required 0", tx_data); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (noRoute !== 1'b0) begin errors++; $display("FAIL reset_noRoute: got %b required 0", noRoute); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    nrst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int k;
    bit ok;
    tbl_id[0] = 16'd1;  tbl_q[0] = 16'h3000;
    tbl_id[1] = 16'd17; tbl_q[1] = 16'hB800;
    tx_ready = 1'b1;
    start_packet(3'b101, 16'h0042, 16'd3, 16'h0007, 16'h1234, 16'd2, k);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
    // en and input changes during the scan must be ignored.
    @(posedge clk);
    #1;
    myNodeID = 16'h5555;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: done not seen within 100 cycles"); end
    checks++; if (first_valid_cyc - k != 3) begin errors++; $display("FAIL basic_latency: got %0d required 3", first_valid_cyc - k); end
    checks++; if (last_hs_cyc - first_valid_cyc != NW - 1) begin errors++; $display("FAIL basic_contiguous: got %0d required %0d", last_hs_cyc - first_valid_cyc, NW - 1); end
    checks++; if (done_cyc - last_hs_cyc != 1) begin errors++; $display("FAIL basic_done_delay: got %0d required 1", done_cyc - last_hs_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
    checks++; if (hs_cnt != NW) begin errors++; $display("FAIL basic_word_count: got %0d required %0d", hs_cnt, NW); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_tie;
    int k;
    bit ok;
    tbl_id[0] = 16'd3; tbl_q[0] = 16'h4000;
    tbl_id[1] = 16'd9; tbl_q[1] = 16'h4000;
    tx_ready = 1'b1;
    start_packet(3'b001, 16'h0010, 16'd1, 16'h0002, 16'h0F00, 16'd2, k);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_done_timeout: done not seen"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tie_leftover: got %0d words left required 0", exp_q.size()); end
  endtask

  task automatic test_no_route;
    int k;
    bit ok;
    tx_ready = 1'b1;
    start_packet(3'b010, 16'h0077, 16'd9, 16'h0001, 16'h0100, 16'd0, k);
    checks++; if (noRoute !== 1'b1) begin errors++; $display("FAIL noroute_set: got %b required 1", noRoute); end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL noroute_done_timeout: done not seen"); end
    checks++; if (hs_cnt != NW) begin errors++; $display("FAIL noroute_word_count: got %0d required %0d", hs_cnt, NW); end
    checks++; if (noRoute !== 1'b1) begin errors++; $display("FAIL noroute_held: got %b required 1", noRoute); end
    // A non-empty table on the next start clears the flag.
    tbl_id[0] = 16'd5; tbl_q[0] = 16'h0001;
    start_packet(3'b101, 16'h0077, 16'd9, 16'h0001, 16'h0100, 16'd1, k);
    checks++; if (noRoute !== 1'b0) begin errors++; $display("FAIL noroute_clear: got %b required 0", noRoute); end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL noroute2_done_timeout: done not seen"); end
  endtask

  task automatic test_random_tables;
    int k;
    bit ok;
    int counts [2] = '{20, 100};
    int lat_req;
    tx_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 32; i++) begin
        tbl_id[i] = 16'($urandom_range(0, 16'hFFFE));
        tbl_q[i]  = 16'($urandom_range(0, 7) << 12);
      end
      start_packet(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), 16'(counts[t]), k);
      lat_req = (counts[t] > 32) ? 33 : counts[t] + 1;
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done_timeout: done not seen", t); end
      checks++; if (first_valid_cyc - k != lat_req) begin errors++; $display("FAIL rand%0d_latency: got %0d required %0d", t, first_valid_cyc - k, lat_req); end
    end
  endtask

  task automatic test_ready_toggle;
    int k;
    bit ok;
    tbl_id[0] = 16'd1;  tbl_q[0] = 16'h3000;
    tbl_id[1] = 16'd17; tbl_q[1] = 16'hB800;
    tbl_id[2] = 16'd22; tbl_q[2] = 16'h7000;
    tx_ready = 1'b0;
    start_packet(3'b011, 16'h00AA, 16'd4, 16'h0003, 16'h2222, 16'd3, k);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      tx_ready = ~tx_ready;
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL toggle_done_timeout: done not seen"); end
    checks++; if (hs_cnt != NW) begin errors++; $display("FAIL toggle_word_count: got %0d required %0d", hs_cnt, NW); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL toggle_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid_send;
    int k;
    bit ok;
    tbl_id[0] = 16'd8; tbl_q[0] = 16'h1111;
    tx_ready = 1'b1;
    start_packet(3'b101, 16'h0BAD, 16'd2, 16'h0004, 16'h3333, 16'd1, k);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hs_cnt == 3) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL midsend_reach_timeout: word 3 not reached"); end
    tx_ready = 1'b0;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 16'd0 || done !== 1'b0 || noRoute !== 1'b0 || rd_index !== 5'd0) begin
      errors++;
      $display("FAIL midsend_reset_outputs: busy=%b valid=%b data=%h done=%b noRoute=%b rd=%h required all 0",
               busy, tx_valid, tx_data, done, noRoute, rd_index);
    end
    nrst = 1'b0;
    exp_q.delete();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midsend_abandon_done: got %0d required 0", done_cnt); end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    tbl_id[0] = 16'd12; tbl_q[0] = 16'h2222;
    tbl_id[1] = 16'd13; tbl_q[1] = 16'h2223;
    start_packet(3'b001, 16'h0C0C, 16'd5, 16'h0006, 16'h4444, 16'd2, k);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midsend_fresh_timeout: done not seen"); end
    checks++; if (hs_cnt != NW) begin errors++; $display("FAIL midsend_fresh_words: got %0d required %0d", hs_cnt, NW); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midsend_fresh_done: got %0d required 1", done_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl_id[i] = 16'(i + 100);
      tbl_q[i]  = 16'd0;
    end
    hs_cnt = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    last_hs_cyc = 0;
    done_cyc = 0;
    test_reset();
    test_basic();
    test_tie();
    test_no_route();
    test_random_tables();
    test_ready_toggle();
    test_reset_mid_send();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d words left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
